// File: rtl/mdu_unit_if.sv
// Operand/result bundle between the E-stage issue logic and the multiply/divide unit.
interface mdu_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic        busy;
    logic        md_pending;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output start, op, a, b, rd_hi,
        input  busy, md_pending, hi, lo, rd_data
    );

    modport slave (
        input  start, op, a, b, rd_hi,
        output busy, md_pending, hi, lo, rd_data
    );
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, computes at the start edge, and
// commits after a fixed busy window so the hazard unit can model the latency.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);

    localparam int unsigned CNT_MAX  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_CLOG = $clog2(CNT_MAX + 1);
    localparam int unsigned CNT_W    = (CNT_CLOG > 4) ? CNT_CLOG : 4;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        res_hi_q, res_hi_d;
    logic [31:0]        res_lo_q, res_lo_d;
    logic               dz_q, dz_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_md_c;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        div_b, quo_u, rem_u;
    logic [31:0]        abs_a, abs_b, quo_mag, rem_mag, quo_s, rem_s;

    assign is_md_c = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);

    // Arithmetic is evaluated in the start cycle; the busy window only models latency.
    always_comb begin : arith_comb
        prod_s  = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
        prod_u  = {32'd0, bus.a} * {32'd0, bus.b};
        div_b   = (bus.b == 32'd0) ? 32'd1 : bus.b;
        quo_u   = bus.a / div_b;
        rem_u   = bus.a % div_b;
        abs_a   = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
        abs_b   = bus.b[31] ? (~bus.b + 32'd1) : div_b;
        quo_mag = abs_a / abs_b;
        rem_mag = abs_a % abs_b;
        quo_s   = (bus.a[31] ^ bus.b[31]) ? (~quo_mag + 32'd1) : quo_mag;
        rem_s   = bus.a[31] ? (~rem_mag + 32'd1) : rem_mag;
    end

    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin : next_state_comb
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (is_md_c) state_d = S_RUN;
            S_RUN:   if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Starts are only honoured in IDLE; a start during RUN is dropped.
    always_comb begin : output_comb
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT: begin
                            res_hi_d = prod_s[63:32];
                            res_lo_d = prod_s[31:0];
                            dz_d     = 1'b0;
                            cnt_d    = CNT_W'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            res_hi_d = prod_u[63:32];
                            res_lo_d = prod_u[31:0];
                            dz_d     = 1'b0;
                            cnt_d    = CNT_W'(MULT_CYCLES);
                        end
                        OP_DIV: begin
                            res_hi_d = rem_s;
                            res_lo_d = quo_s;
                            dz_d     = (bus.b == 32'd0);
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                        OP_DIVU: begin
                            res_hi_d = rem_u;
                            res_lo_d = quo_u;
                            dz_d     = (bus.b == 32'd0);
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Divide-by-zero leaves HI/LO untouched but still burns the full window.
                if ((cnt_q == CNT_W'(1)) && !dz_q) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy       = (state_q == S_RUN);
    assign bus.md_pending = is_md_c || (state_q == S_RUN);
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.rd_data    = bus.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, corner sequences
// and randomized ops against a cycle-level behavioural model of HI/LO.
module tb_mdu_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_unit_if bus();

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int illegal    = 0;

    // Model: architectural HI/LO, pending result, cycles of busy left.
    logic [31:0] m_hi, m_lo, m_ph, m_pl;
    int          m_left;
    bit          m_commit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0;
        m_left = 0; m_commit = 1'b0;
    endfunction

    function automatic bit is_md(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic void model_edge(input logic st, input logic [2:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p;
        if (m_left > 0) begin
            if (st && op >= 3'd1 && op <= 3'd6) begin
                illegal++;
                $display("note: start op %0d while busy at %0t (hazard violation, ignored)", op, $time);
            end
            m_left--;
            if (m_left == 0 && m_commit) begin
                m_hi = m_ph;
                m_lo = m_pl;
            end
        end else if (st) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = {32'd0, a};
            ub = {32'd0, b};
            case (op)
                3'd1: begin p = 64'(sa * sb); {m_ph, m_pl} = p; m_commit = 1'b1; m_left = MC; end
                3'd2: begin p = 64'(ua * ub); {m_ph, m_pl} = p; m_commit = 1'b1; m_left = MC; end
                3'd3: begin
                    m_left = DC;
                    m_commit = (b != 32'd0);
                    if (m_commit) begin
                        sq = sa / sb; sr = sa % sb;
                        m_pl = 32'(sq); m_ph = 32'(sr);
                    end
                end
                3'd4: begin
                    m_left = DC;
                    m_commit = (b != 32'd0);
                    if (m_commit) begin
                        m_pl = 32'(ua / ub); m_ph = 32'(ua % ub);
                    end
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endfunction

    // One clock: drive just after the rising edge, check at the falling edge.
    task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rh, input logic rs);
        #1;
        bus.start = st; bus.op = op; bus.a = a; bus.b = b; bus.rd_hi = rh;
        reset = rs;
        if (!rs) model_reset();
        @(negedge clk);
        chk("busy",       32'(bus.busy),       32'(m_left > 0));
        chk("md_pending", 32'(bus.md_pending), 32'((st && is_md(op)) || (m_left > 0)));
        chk("hi",         bus.hi,              m_hi);
        chk("lo",         bus.lo,              m_lo);
        chk("rd_data",    bus.rd_data,         rh ? m_hi : m_lo);
        @(posedge clk);
        if (rs) model_edge(st, op, a, b);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MC;
        if (op == 3'd3 || op == 3'd4) return DC;
        return 0;
    endfunction

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          guard;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[4]  = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h7FFF_FFFC};
        vecs[5]  = '{3'd6, 32'h9ABC_DEF0, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[6]  = '{3'd3, 32'h0000_0064, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[7]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[8]  = '{3'd0, 32'hDEAD_BEEF, 32'h0000_0001, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[9]  = '{3'd7, 32'hDEAD_BEEF, 32'h0000_0001, 32'h1234_5678, 32'h9ABC_DEF0};
        vecs[10] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[11] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[12] = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        reset = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.rd_hi = 1'b0;
        model_reset();
        @(posedge clk);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 3'd1, 32'd1, 32'd1, 1'b0, 1'b0);

        // Directed table: each op followed by its busy window, then HI/LO vs constants.
        for (int i = 0; i < NV; i++) begin
            cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b1);
            idle(latency(vecs[i].op));
            #1;
            chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
        end

        // Illegal start during a multiply is dropped.
        cycle(1'b1, 3'd1, 32'd3, 32'd4, 1'b0, 1'b1);
        idle(1);
        cycle(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        idle(MC - 2);
        #1;
        chk("illegal_hi", bus.hi, 32'd0);
        chk("illegal_lo", bus.lo, 32'd12);
        chk("illegal_busy_after", 32'(bus.busy), 32'd0);

        // Reset pulsed mid-divide: everything clears and the divide never lands.
        cycle(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0, 1'b1);
        idle(3);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(DC + 2);
        #1;
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        cycle(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b1);
        idle(MC);
        #1;
        chk("post_reset_mult_lo", bus.lo, 32'd42);
        chk("post_reset_mult_hi", bus.hi, 32'd0);

        // Randomized legal traffic against the model.
        for (int n = 0; n < 80; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = rand_word();
            rb  = rand_word();
            cycle(1'b1, rop, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            guard = 0;
            while (m_left > 0 && guard < 20) begin
                idle(1);
                guard++;
            end
            if (guard >= 20) chk("busy_window_bound", 32'(m_left), 32'd0);
            idle(int'($urandom_range(0, 1)));
        end

        chk("illegal_start_count", 32'(illegal), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
